// File: rtl/instr_seq_ctrl.sv
// Instruction-cycle sequencer: owns the sequence count, T0..T7 decode and fetch/decode/indirect/execute/interrupt phasing.
// Optional single-step support (input step, PAUSE state) is built when STEP_MODE_EN is defined.
module instr_seq_ctrl #(
    parameter int FETCH_WAIT_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mem_ready,
    input  logic [2:0] ir_opcode,
    input  logic       ir_i,
    input  logic       halt_req,
    input  logic       ien,
    input  logic       int_req,
`ifdef STEP_MODE_EN
    input  logic       step,
`endif
    output logic [2:0] sc_val,
    output logic [7:0] t_dec,
    output logic       sc_inc,
    output logic       sc_clr,
    output logic [2:0] phase,
    output logic       r_flag,
    output logic       ien_clr,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_INDIR  = 3'd3,
        S_EXEC   = 3'd4,
        S_INTR   = 3'd5,
        S_HALT   = 3'd6
`ifdef STEP_MODE_EN
        ,
        S_PAUSE  = 3'd7
`endif
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT_MAX - 1);

`ifdef STEP_MODE_EN
    localparam state_t DONE_ST = S_PAUSE;
`else
    localparam state_t DONE_ST = S_FETCH;
`endif

    state_t     state, state_nxt;
    logic [2:0] sc, sc_nxt;
    logic [3:0] wait_cnt, wait_nxt;
    logic       r_q, r_nxt;
    logic       inc_c, clr_c, ien_clr_c, tmo_c;
    logic [2:0] last_t;

    // Final execute T-state; indirect memory-reference instructions run one state later.
    always_comb begin
        case (ir_opcode)
            3'd0, 3'd1, 3'd2, 3'd5: last_t = 3'd5;
            3'd3, 3'd4:             last_t = 3'd4;
            3'd6:                   last_t = 3'd6;
            default:                last_t = 3'd3;
        endcase
        if (ir_i && ir_opcode != 3'd7) begin
            last_t = last_t + 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        r_nxt     = r_q;
        inc_c     = 1'b0;
        clr_c     = 1'b0;
        ien_clr_c = 1'b0;
        tmo_c     = 1'b0;

        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (sc == 3'd0) begin
                    if (r_q) begin
                        state_nxt = S_INTR;
                    end else begin
                        inc_c = 1'b1;
                    end
                end else if (sc == 3'd1) begin
                    if (mem_ready) begin
                        inc_c     = 1'b1;
                        wait_nxt  = 4'd0;
                        state_nxt = S_DECODE;
                    end else if (wait_cnt >= WAIT_LAST) begin
                        // Memory never answered: flag it and retry the fetch from T0.
                        tmo_c    = 1'b1;
                        clr_c    = 1'b1;
                        wait_nxt = 4'd0;
                    end else begin
                        wait_nxt = wait_cnt + 4'd1;
                    end
                end else begin
                    clr_c = 1'b1;
                end
            end
            S_DECODE: begin
                inc_c     = 1'b1;
                state_nxt = (ir_opcode != 3'd7 && ir_i) ? S_INDIR : S_EXEC;
            end
            S_INDIR: begin
                inc_c     = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (sc == last_t) begin
                    clr_c     = 1'b1;
                    state_nxt = (ir_opcode == 3'd7 && halt_req) ? S_HALT : DONE_ST;
                end else begin
                    inc_c = 1'b1;
                end
            end
            S_INTR: begin
                if (sc == 3'd2) begin
                    ien_clr_c = 1'b1;
                    clr_c     = 1'b1;
                    r_nxt     = 1'b0;
                    state_nxt = DONE_ST;
                end else begin
                    inc_c = 1'b1;
                end
            end
`ifdef STEP_MODE_EN
            S_PAUSE: begin
                if (step) begin
                    state_nxt = S_FETCH;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
                clr_c     = 1'b1;
            end
        endcase

        // R only latches once the operand phase is under way; the current instruction still runs to completion.
        if (!r_q && ien && int_req && (state == S_EXEC || state == S_INDIR) && sc > 3'd2) begin
            r_nxt = 1'b1;
        end
`ifdef STEP_MODE_EN
        if (!r_q && ien && int_req && state == S_PAUSE) begin
            r_nxt = 1'b1;
        end
`endif

        if (clr_c) begin
            sc_nxt = 3'd0;
        end else if (inc_c) begin
            sc_nxt = sc + 3'd1;
        end else begin
            sc_nxt = sc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            sc       <= 3'd0;
            wait_cnt <= 4'd0;
            r_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            sc       <= sc_nxt;
            wait_cnt <= wait_nxt;
            r_q      <= r_nxt;
        end
    end

    always_comb begin
        t_dec = 8'h00;
        if (state == S_FETCH || state == S_DECODE || state == S_INDIR ||
            state == S_EXEC  || state == S_INTR) begin
            t_dec = 8'h01 << sc;
        end
    end

    assign sc_val      = sc;
    assign phase       = state;
    assign sc_inc      = inc_c;
    assign sc_clr      = clr_c;
    assign r_flag      = r_q;
    assign ien_clr     = ien_clr_c;
    assign err_timeout = tmo_c;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: per-cycle stimulus and expected outputs are queued, then replayed and compared.
module tb_instr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, mem_ready, ir_i, halt_req, ien, int_req;
    logic [2:0] ir_opcode;
    logic [2:0] sc_val, phase;
    logic [7:0] t_dec;
    logic       sc_inc, sc_clr, r_flag, ien_clr, err_timeout;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       mr;
        logic [2:0] op;
        logic       i;
        logic       halt;
        logic       ien;
        logic       iq;
    } stim_t;

    typedef struct packed {
        logic [2:0] sc;
        logic [7:0] t;
        logic       inc;
        logic       clr;
        logic [2:0] ph;
        logic       r;
        logic       ic;
        logic       to;
    } out_t;

    typedef struct packed {
        logic  chk;
        stim_t s;
        out_t  x;
    } entry_t;

    entry_t sb[$];

    instr_seq_ctrl #(.FETCH_WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready),
        .ir_opcode(ir_opcode), .ir_i(ir_i), .halt_req(halt_req),
        .ien(ien), .int_req(int_req),
        .sc_val(sc_val), .t_dec(t_dec), .sc_inc(sc_inc), .sc_clr(sc_clr),
        .phase(phase), .r_flag(r_flag), .ien_clr(ien_clr), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(int r, int s, int mr, int op, int i, int h, int ie, int iq);
        stim_t v;
        v.rst = r[0]; v.start = s[0]; v.mr = mr[0]; v.op = op[2:0];
        v.i = i[0]; v.halt = h[0]; v.ien = ie[0]; v.iq = iq[0];
        return v;
    endfunction

    // Expected outputs; t_dec follows from the count only in the five active phases.
    function automatic out_t ex(int sc, int ph, int inc, int clr, int r, int ic, int to);
        out_t v;
        v.sc = sc[2:0]; v.ph = ph[2:0]; v.inc = inc[0]; v.clr = clr[0];
        v.r = r[0]; v.ic = ic[0]; v.to = to[0];
        v.t = (ph >= 1 && ph <= 5) ? (8'h01 << sc[2:0]) : 8'h00;
        return v;
    endfunction

    function automatic string fmt(out_t v);
        return $sformatf("sc=%0d t=%h inc=%b clr=%b ph=%0d r=%b ic=%b to=%b",
                         v.sc, v.t, v.inc, v.clr, v.ph, v.r, v.ic, v.to);
    endfunction

    task automatic push(input stim_t s, input out_t x);
        sb.push_back({1'b1, s, x});
    endtask

    task automatic push_nc(input stim_t s);
        sb.push_back({1'b0, s, ex(0, 0, 0, 0, 0, 0, 0)});
    endtask

    task automatic apply(input stim_t s, output out_t a);
        rst = s.rst; start = s.start; mem_ready = s.mr; ir_opcode = s.op;
        ir_i = s.i; halt_req = s.halt; ien = s.ien; int_req = s.iq;
        #2;
        a.sc = sc_val; a.t = t_dec; a.inc = sc_inc; a.clr = sc_clr;
        a.ph = phase; a.r = r_flag; a.ic = ien_clr; a.to = err_timeout;
        @(negedge clk);
    endtask

    task automatic do_reset();
        out_t a;
        apply(st(0, 0, 0, 0, 0, 0, 0, 0), a);
    endtask

    task automatic test_reset();
        entry_t e; out_t a; int n = 0;
        push(st(0, 1, 1, 0, 0, 0, 1, 1), ex(0, 0, 0, 0, 0, 0, 0));
        push(st(1, 0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        push(st(1, 0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); apply(e.s, a); n++;
            if (e.chk) begin
                checks++;
                if (a !== e.x) begin
                    errors++;
                    $display("[TB] FAIL reset c%0d: got %s want %s", n, fmt(a), fmt(e.x));
                end
            end
        end
    endtask

    task automatic test_basic();
        entry_t e; out_t a; int n = 0;
        do_reset();
        push(st(1, 1, 1, 2, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        push(st(1, 0, 1, 2, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 2, 0, 0, 0, 0), ex(1, 1, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 2, 0, 0, 0, 0), ex(2, 2, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 2, 0, 0, 0, 0), ex(3, 4, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 2, 0, 0, 0, 0), ex(4, 4, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 2, 0, 0, 0, 0), ex(5, 4, 0, 1, 0, 0, 0));
        push(st(1, 0, 1, 2, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); apply(e.s, a); n++;
            if (e.chk) begin
                checks++;
                if (a !== e.x) begin
                    errors++;
                    $display("[TB] FAIL basic_lda c%0d: got %s want %s", n, fmt(a), fmt(e.x));
                end
            end
        end
    endtask

    task automatic test_indirect();
        entry_t e; out_t a; int n = 0;
        do_reset();
        push(st(1, 1, 1, 6, 1, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 1, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 1, 0, 0, 0), ex(1, 1, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 1, 0, 0, 0), ex(2, 2, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 1, 0, 0, 0), ex(3, 3, 1, 0, 0, 0, 0));
        for (int t = 4; t <= 7; t++) begin
            push(st(1, 0, 1, 6, 1, 0, 0, 0), ex(t, 4, (t != 7) ? 1 : 0, (t == 7) ? 1 : 0, 0, 0, 0));
        end
        push(st(1, 0, 1, 6, 1, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); apply(e.s, a); n++;
            if (e.chk) begin
                checks++;
                if (a !== e.x) begin
                    errors++;
                    $display("[TB] FAIL indirect_isz c%0d: got %s want %s", n, fmt(a), fmt(e.x));
                end
            end
        end
    endtask

    task automatic test_timeout();
        entry_t e; out_t a; int n = 0;
        do_reset();
        push(st(1, 1, 0, 2, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        push(st(1, 0, 0, 2, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) push(st(1, 0, 0, 2, 0, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, 0));
        push(st(1, 0, 0, 2, 0, 0, 0, 0), ex(1, 1, 0, 1, 0, 0, 1));
        push(st(1, 0, 0, 2, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) push(st(1, 0, 0, 2, 0, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, 0));
        push(st(1, 0, 1, 2, 0, 0, 0, 0), ex(1, 1, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 2, 0, 0, 0, 0), ex(2, 2, 1, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); apply(e.s, a); n++;
            if (e.chk) begin
                checks++;
                if (a !== e.x) begin
                    errors++;
                    $display("[TB] FAIL fetch_timeout c%0d: got %s want %s", n, fmt(a), fmt(e.x));
                end
            end
        end
    endtask

    task automatic test_interrupt();
        entry_t e; out_t a; int n = 0;
        do_reset();
        push(st(1, 1, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        push(st(1, 0, 1, 0, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 0, 0, 0, 0, 0), ex(1, 1, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 0, 0, 0, 1, 1), ex(2, 2, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 0, 0, 0, 0, 0), ex(3, 4, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 0, 0, 0, 1, 1), ex(4, 4, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 0, 0, 0, 1, 0), ex(5, 4, 0, 1, 1, 0, 0));
        push(st(1, 0, 1, 0, 0, 0, 1, 0), ex(0, 1, 0, 0, 1, 0, 0));
        push(st(1, 0, 0, 0, 0, 0, 1, 0), ex(0, 5, 1, 0, 1, 0, 0));
        push(st(1, 0, 0, 0, 0, 0, 1, 0), ex(1, 5, 1, 0, 1, 0, 0));
        push(st(1, 0, 0, 0, 0, 0, 1, 0), ex(2, 5, 0, 1, 1, 1, 0));
        push(st(1, 0, 1, 0, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); apply(e.s, a); n++;
            if (e.chk) begin
                checks++;
                if (a !== e.x) begin
                    errors++;
                    $display("[TB] FAIL interrupt c%0d: got %s want %s", n, fmt(a), fmt(e.x));
                end
            end
        end
    endtask

    task automatic test_halt();
        entry_t e; out_t a; int n = 0;
        do_reset();
        push(st(1, 1, 1, 7, 0, 1, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        push(st(1, 0, 1, 7, 0, 1, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 7, 0, 1, 0, 0), ex(1, 1, 1, 0, 0, 0, 0));
        push(st(1, 1, 1, 7, 0, 1, 0, 0), ex(2, 2, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 7, 0, 1, 0, 0), ex(3, 4, 0, 1, 0, 0, 0));
        push(st(1, 0, 1, 7, 0, 1, 1, 1), ex(0, 6, 0, 0, 0, 0, 0));
        push(st(1, 1, 1, 7, 0, 1, 1, 1), ex(0, 6, 0, 0, 0, 0, 0));
        push(st(1, 0, 1, 7, 0, 1, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); apply(e.s, a); n++;
            if (e.chk) begin
                checks++;
                if (a !== e.x) begin
                    errors++;
                    $display("[TB] FAIL halt c%0d: got %s want %s", n, fmt(a), fmt(e.x));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        entry_t e; out_t a; int n = 0;
        do_reset();
        push(st(1, 1, 1, 6, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 0, 0, 0, 0), ex(1, 1, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 0, 0, 0, 0), ex(2, 2, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 0, 0, 1, 1), ex(3, 4, 1, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 0, 0, 0, 0), ex(4, 4, 1, 0, 1, 0, 0));
        push_nc(st(0, 0, 1, 6, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        push(st(1, 0, 1, 6, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); apply(e.s, a); n++;
            if (e.chk) begin
                checks++;
                if (a !== e.x) begin
                    errors++;
                    $display("[TB] FAIL reset_mid c%0d: got %s want %s", n, fmt(a), fmt(e.x));
                end
            end
        end
    endtask

    // Continuous stream of instructions; final T-states come from the bench's own opcode table.
    task automatic test_back_to_back();
        entry_t e; out_t a; int n = 0;
        int op_l[13]  = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 3, 4, 5, 7};
        int ind_l[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        int fin_d[8]  = '{5, 5, 5, 4, 4, 5, 6, 3};
        int op, ind, fin, first;
        do_reset();
        push(st(1, 1, 1, op_l[0], ind_l[0], 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 13; k++) begin
            op = op_l[k];
            ind = (ind_l[k] != 0 && op != 7) ? 1 : 0;
            fin = fin_d[op] + ind;
            first = ind ? 4 : 3;
            push(st(1, 0, 1, op, ind_l[k], 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
            push(st(1, 0, 1, op, ind_l[k], 0, 0, 0), ex(1, 1, 1, 0, 0, 0, 0));
            push(st(1, 0, 1, op, ind_l[k], 0, 0, 0), ex(2, 2, 1, 0, 0, 0, 0));
            if (ind != 0) push(st(1, 0, 1, op, ind_l[k], 0, 0, 0), ex(3, 3, 1, 0, 0, 0, 0));
            for (int t = first; t <= fin; t++) begin
                push(st(1, 0, 1, op, ind_l[k], 0, 0, 0),
                     ex(t, 4, (t != fin) ? 1 : 0, (t == fin) ? 1 : 0, 0, 0, 0));
            end
        end
        push(st(1, 0, 1, 0, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); apply(e.s, a); n++;
            if (e.chk) begin
                checks++;
                if (a !== e.x) begin
                    errors++;
                    $display("[TB] FAIL back_to_back c%0d op=%0d i=%b: got %s want %s",
                             n, e.s.op, e.s.i, fmt(a), fmt(e.x));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mem_ready = 1'b0; ir_opcode = 3'd0;
        ir_i = 1'b0; halt_req = 1'b0; ien = 1'b0; int_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] starting instr_seq_ctrl bench");
        test_reset();
        test_basic();
        test_indirect();
        test_timeout();
        test_interrupt();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
